// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states
// and the default bus timeout.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/acknowledge data-memory bus between the MEM stage (master) and
// the data memory (slave).
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering for both directions: byte enables and
// replicated store data out, aligned and extended load data in.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select lanes and extend according to access size
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    load_ext  = rdata;
    byte_s    = rdata[{addr_lo, 3'b000} +: 8];
    half_s    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        load_ext  = {{24{sign_ext & byte_s[7]}}, byte_s};
      end
      SIZE_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        load_ext  = {{16{sign_ext & half_s[15]}}, half_s};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        load_ext  = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: passes ALU results straight through and runs byte,
// halfword and word accesses over the data bus, stalling upstream meanwhile.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [1:0]  in_size,
  input  logic        in_signed,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [3:0]  in_rd,
  input  logic        in_rf_en,
  output logic        stall,
  mem_access_stage_if.master bus,
  output logic [31:0] load_data,
  output logic [31:0] nonload_data,
  output logic [3:0]  rd_out,
  output logic        load_inst,
  output logic        rf_en_out,
  output logic        abort
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          signed_q, signed_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    rd_q, rd_d;
  logic          rf_en_q, rf_en_d;
  logic          load_q, load_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          abort_q, abort_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic          mem_op_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_rep_s;
  logic [31:0]   load_ext_s;

  assign mem_op_s = in_valid & (in_load | in_store);

  mem_lane_align u_align (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .sign_ext  (signed_q),
    .rdata     (rdata_q),
    .wdata     (wdata_q),
    .be        (be_s),
    .wdata_rep (wdata_rep_s),
    .load_ext  (load_ext_s)
  );

  // State and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= 32'h0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      wdata_q    <= 32'h0;
      rd_q       <= 4'h0;
      rf_en_q    <= 1'b0;
      load_q     <= 1'b0;
      rdata_q    <= 32'h0;
      abort_q    <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      rf_en_q    <= rf_en_d;
      load_q     <= load_d;
      rdata_q    <= rdata_d;
      abort_q    <= abort_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic; a load+store op is handled as a load
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    signed_d   = signed_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    rf_en_d    = rf_en_q;
    load_d     = load_q;
    rdata_d    = rdata_q;
    abort_d    = abort_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_op_s) begin
          addr_d     = in_addr;
          size_d     = in_size;
          signed_d   = in_signed;
          wdata_d    = in_wdata;
          rd_d       = in_rd;
          rf_en_d    = in_rf_en;
          load_d     = in_load;
          rdata_d    = 32'h0;
          abort_d    = 1'b0;
          wait_cnt_d = '0;
          state_d    = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (bus.mem_ack) begin
          rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          abort_d = 1'b1;
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      RESP: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage outputs and bus drive; everything defaults to a quiet bubble
  always_comb begin
    stall         = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_be    = 4'h0;
    load_data     = 32'h0;
    nonload_data  = 32'h0;
    rd_out        = 4'h0;
    load_inst     = 1'b0;
    rf_en_out     = 1'b0;
    abort         = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op_s) begin
          stall = 1'b1;
        end else begin
          nonload_data = in_valid ? in_addr : 32'h0;
          rd_out       = in_valid ? in_rd : 4'h0;
          rf_en_out    = in_valid & in_rf_en;
        end
      end
      WAIT: begin
        stall         = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = ~load_q;
        bus.mem_addr  = {addr_q[31:2], 2'b00};
        bus.mem_wdata = wdata_rep_s;
        bus.mem_be    = be_s;
      end
      RESP: begin
        nonload_data = addr_q;
        rd_out       = rd_q;
        load_inst    = load_q;
        load_data    = (load_q & ~abort_q) ? load_ext_s : 32'h0;
        rf_en_out    = rf_en_q & ~abort_q;
        abort        = abort_q;
      end
      default: stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a
// behavioural model of lane steering, extension and bus timing.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_load, in_store, in_signed, in_rf_en;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic [3:0]  in_rd;
  logic        stall, load_inst, rf_en_out, abort;
  logic [31:0] load_data, nonload_data;
  logic [3:0]  rd_out;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_load      (in_load),
    .in_store     (in_store),
    .in_size      (in_size),
    .in_signed    (in_signed),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .in_rd        (in_rd),
    .in_rf_en     (in_rf_en),
    .stall        (stall),
    .bus          (bus),
    .load_data    (load_data),
    .nonload_data (nonload_data),
    .rd_out       (rd_out),
    .load_inst    (load_inst),
    .rf_en_out    (rf_en_out),
    .abort        (abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: byte enables, replicated store data, extended load data
  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'd0) return 4'(1 << a);
    if (sz == 2'd1) return (a >= 2'd2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd0) return {24'h0, w[7:0]} * 32'h0101_0101;
    if (sz == 2'd1) return {16'h0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sg,
                                           input logic [1:0] a, input logic [31:0] r);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (r >> (8 * a)) & 32'hFF;
      if (sg && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = (r >> ((a >= 2'd2) ? 16 : 0)) & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = r;
    end
    return v;
  endfunction

  task automatic alu_op(input logic [31:0] a, input logic [3:0] rd, input logic rfe);
    @(posedge clk); #1;
    in_valid = 1'b1; in_load = 1'b0; in_store = 1'b0;
    in_addr = a; in_rd = rd; in_rf_en = rfe; in_wdata = $urandom;
    @(negedge clk);
    check("alu_nonload", nonload_data, a);
    check("alu_rd", {28'h0, rd_out}, {28'h0, rd});
    check("alu_rf_en", {31'h0, rf_en_out}, {31'h0, rfe});
    check("alu_stall", {31'h0, stall}, 32'h0);
    check("alu_req", {31'h0, bus.mem_req}, 32'h0);
    check("alu_li", {31'h0, load_inst}, 32'h0);
  endtask

  // ack_k = WAIT cycle carrying the ack; ack_k > TO means no ack at all
  task automatic mem_op(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                        input logic [3:0] rd, input logic rfe, input int ack_k);
    int   stall_cycles;
    logic acked;
    stall_cycles = 0;
    acked = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz; in_signed = sg;
    in_addr = a; in_wdata = wd; in_rd = rd; in_rf_en = rfe;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("cap_stall", {31'h0, stall}, 32'h1);
    check("cap_req", {31'h0, bus.mem_req}, 32'h0);
    check("cap_rf_en", {31'h0, rf_en_out}, 32'h0);
    if (stall) stall_cycles++;
    for (int w = 1; w <= TO; w++) begin
      @(posedge clk); #1;
      bus.mem_ack   = (w == ack_k);
      bus.mem_rdata = (w == ack_k) ? rdat : $urandom;
      @(negedge clk);
      if (stall) stall_cycles++;
      check("wait_req", {31'h0, bus.mem_req}, 32'h1);
      check("wait_rf_en", {31'h0, rf_en_out}, 32'h0);
      check("wait_addr", bus.mem_addr, {a[31:2], 2'b00});
      check("wait_be", {28'h0, bus.mem_be}, {28'h0, ld ? exp_be(sz, a[1:0]) : exp_be(sz, a[1:0])});
      check("wait_we", {31'h0, bus.mem_we}, {31'h0, ~ld});
      if (!ld) check("wait_wdata", bus.mem_wdata, exp_wdata(sz, wd));
      if (w == ack_k) begin
        acked = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = $urandom;
    @(negedge clk);
    check("stall_cycles", stall_cycles, acked ? ack_k + 1 : TO + 1);
    check("resp_stall", {31'h0, stall}, 32'h0);
    check("resp_req", {31'h0, bus.mem_req}, 32'h0);
    check("resp_abort", {31'h0, abort}, {31'h0, ~acked});
    check("resp_rf_en", {31'h0, rf_en_out}, {31'h0, rfe & acked});
    check("resp_li", {31'h0, load_inst}, {31'h0, ld});
    check("resp_load", load_data, (ld && acked) ? exp_load(sz, sg, a[1:0], rdat) : 32'h0);
    check("resp_rd", {28'h0, rd_out}, {28'h0, rd});
    check("resp_nonload", nonload_data, a);
    @(posedge clk); #1;
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_size = 2'b00; in_signed = 1'b0;
    in_addr = 32'h0; in_wdata = 32'h0; in_rd = 4'h0; in_rf_en = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    #12;
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_req", {31'h0, bus.mem_req}, 32'h0);
    check("rst_bus", bus.mem_addr | bus.mem_wdata | {28'h0, bus.mem_be} | {31'h0, bus.mem_we}, 32'h0);
    check("rst_data", load_data | nonload_data | {28'h0, rd_out}, 32'h0);
    check("rst_flags", {29'h0, load_inst, rf_en_out, abort}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases
    alu_op(32'h0000_1234, 4'd3, 1'b1);
    mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 4'd5, 1'b1, 1);
    mem_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF_FF7F, 4'd6, 1'b1, 2);
    mem_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF_FF7F, 4'd6, 1'b1, 2);
    mem_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 32'h0, 4'd0, 1'b0, 1);
    mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h1234_5678, 4'd7, 1'b1, TO + 1);
    mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 32'h8765_4321, 4'd8, 1'b1, TO);
    mem_op(1'b1, 1'b1, 2'b01, 1'b1, 32'h502, 32'h0, 32'h8001_7FFF, 4'd9, 1'b1, 1);

    // Reset in the middle of a WAIT
    @(posedge clk); #1;
    in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_size = 2'b10; in_addr = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("prerst_req", {31'h0, bus.mem_req}, 32'h1);
    rst_n = 1'b0; in_valid = 1'b0; in_load = 1'b0;
    #1;
    check("midrst_req", {31'h0, bus.mem_req}, 32'h0);
    check("midrst_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("late_ack_req", {31'h0, bus.mem_req}, 32'h0);
    check("late_ack_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_flags", {29'h0, load_inst, rf_en_out, abort}, 32'h0);
    mem_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h301, 32'h0, 32'h0000_AB00, 4'd2, 1'b1, 1);

    // Randomized mix of ALU ops and memory ops
    for (int i = 0; i < 40; i++) begin
      logic [1:0] kind;
      kind = 2'($urandom_range(0, 3));
      if (kind == 2'd0) begin
        alu_op($urandom, 4'($urandom), 1'($urandom));
      end else begin
        mem_op(kind != 2'd2, kind != 2'd1, 2'($urandom), 1'($urandom), $urandom, $urandom,
               $urandom, 4'($urandom), 1'($urandom), $urandom_range(1, TO + 1));
      end
    end

    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
